id_ex_stage: RTL and testbench

//  ID/EX pipeline register between the decode-side control unit and the EX stage.
//  - Latches the control bundle, operands, extended immediate and register addresses.
//  - Detects load-use hazards, stalls fetch/decode and injects bubbles.
//  - Flushes on a taken jump/branch signalled by EX.

---
 rtl/id_ex_stage_pkg.sv | 27 ++
 rtl/id_ex_stage_if.sv | 42 ++++
 rtl/id_ex_hazard_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared CPU types for the ID/EX boundary: control bundle, NOP constant and
// the ID/EX stall FSM state type.
package cpu_pkg;

    // Control bundle, MSB first in the same order as the decoder emits it.
    typedef struct packed {
        logic       wmem;
        logic       rmem;
        logic       wreg;
        logic       wpc;
        logic       CondEn;
        logic [1:0] jmpF;
        logic [2:0] ALUins;
        logic [1:0] ExtndSel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Width of the extra-bubble counter; bounds LOAD_STALL to 1..7.
    localparam int unsigned IDEX_CNT_W = 3;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } idex_state_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bus: ID-side inputs, EX flush request and the
// registered EX-side bundle with the stall/bubble status.
interface id_ex_if
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4
);
    ctrl_t              id_ctrl;
    logic [DATA_W-1:0]  id_rd1;
    logic [DATA_W-1:0]  id_rd2;
    logic [DATA_W-1:0]  id_ext;
    logic [REG_AW-1:0]  id_rs1;
    logic [REG_AW-1:0]  id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic [REG_AW-1:0]  id_rd;
    logic               ex_flush;

    ctrl_t              ex_ctrl;
    logic [DATA_W-1:0]  ex_rd1;
    logic [DATA_W-1:0]  ex_rd2;
    logic [DATA_W-1:0]  ex_ext;
    logic [REG_AW-1:0]  ex_rd;
    logic               stall;
    logic               bubble;

    // Decode side / environment: drives ID fields and flush, observes EX.
    modport master (
        output id_ctrl, id_rd1, id_rd2, id_ext, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, id_rd, ex_flush,
        input  ex_ctrl, ex_rd1, ex_rd2, ex_ext, ex_rd, stall, bubble
    );

    // The pipeline register itself.
    modport slave (
        input  id_ctrl, id_rd1, id_rd2, id_ext, id_rs1, id_rs2,
               id_use_rs1, id_use_rs2, id_rd, ex_flush,
        output ex_ctrl, ex_rd1, ex_rd2, ex_ext, ex_rd, stall, bubble
    );

endinterface

// File: rtl/id_ex_hazard_detect.sv
// Load-use hazard detector: the instruction in EX is a load whose
// destination matches a source register actually read by the instruction in ID.
module id_ex_hazard_detect #(
    parameter int unsigned REG_AW = 4
) (
    input  logic              rmem_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    output logic              haz_o
);

    // Register 0 is compared like any other register.
    always_comb begin
        haz_o = rmem_i & ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                          (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall insertion and branch flush.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned LOAD_STALL = 1
) (
    input  logic    clk,
    input  logic    rst,
    id_ex_if.slave  bus
);

    if (LOAD_STALL < 1 || LOAD_STALL > 7) begin : g_bad_load_stall
        $error("id_ex_stage: LOAD_STALL must be in 1..7");
    end

    idex_state_t            state_q, state_d;
    logic [IDEX_CNT_W-1:0]  cnt_q, cnt_d;
    ctrl_t                  ctrl_q, ctrl_d;
    logic [DATA_W-1:0]      rd1_q, rd1_d;
    logic [DATA_W-1:0]      rd2_q, rd2_d;
    logic [DATA_W-1:0]      ext_q, ext_d;
    logic [REG_AW-1:0]      rd_q, rd_d;
    logic                   bubble_q, bubble_d;
    logic                   haz;
    logic                   stall_c;
    logic                   load_nop;

    id_ex_hazard_detect #(.REG_AW(REG_AW)) u_haz (
        .rmem_i       (ctrl_q.rmem),
        .ex_rd_i      (rd_q),
        .id_rs1_i     (bus.id_rs1),
        .id_rs2_i     (bus.id_rs2),
        .id_use_rs1_i (bus.id_use_rs1),
        .id_use_rs2_i (bus.id_use_rs2),
        .haz_o        (haz)
    );

    // Stall FSM: flush beats hazard; the first bubble is inserted from RUN,
    // STALL supplies the remaining LOAD_STALL-1 bubbles counted down by cnt.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        load_nop = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.ex_flush) begin
                    load_nop = 1'b1;
                end else if (haz) begin
                    stall_c  = 1'b1;
                    load_nop = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = STALL;
                        cnt_d   = IDEX_CNT_W'(LOAD_STALL - 2);
                    end
                end
            end
            STALL: begin
                load_nop = 1'b1;
                if (bus.ex_flush) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    stall_c = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Next pipeline contents: either the ID instruction or an all-zero NOP.
    always_comb begin
        ctrl_d   = load_nop ? CTRL_NOP : bus.id_ctrl;
        rd1_d    = load_nop ? '0 : bus.id_rd1;
        rd2_d    = load_nop ? '0 : bus.id_rd2;
        ext_d    = load_nop ? '0 : bus.id_ext;
        rd_d     = load_nop ? '0 : bus.id_rd;
        bubble_d = load_nop;
    end

    // State, counter and pipeline registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            ctrl_q   <= CTRL_NOP;
            rd1_q    <= '0;
            rd2_q    <= '0;
            ext_q    <= '0;
            rd_q     <= '0;
            bubble_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            ext_q    <= ext_d;
            rd_q     <= rd_d;
            bubble_q <= bubble_d;
        end
    end

    // Drive the EX side; stall is suppressed while reset is asserted.
    always_comb begin
        bus.ex_ctrl = ctrl_q;
        bus.ex_rd1  = rd1_q;
        bus.ex_rd2  = rd2_q;
        bus.ex_ext  = ext_q;
        bus.ex_rd   = rd_q;
        bus.bubble  = bubble_q;
        bus.stall   = stall_c & ~rst;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (LOAD_STALL=1 and 3) driven with the
// same stimulus and checked against a per-instance behavioural model.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic clk;
    logic rst;

    id_ex_if #(.DATA_W(32), .REG_AW(4)) ifc1 ();
    id_ex_if #(.DATA_W(32), .REG_AW(4)) ifc3 ();

    id_ex_stage #(.DATA_W(32), .REG_AW(4), .LOAD_STALL(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (ifc1)
    );

    id_ex_stage #(.DATA_W(32), .REG_AW(4), .LOAD_STALL(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (ifc3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: 0 -> LOAD_STALL=1, 1 -> LOAD_STALL=3.
    int          ls_val[2] = '{1, 3};
    logic [11:0] m_ctrl[2];
    logic [31:0] m_rd1[2];
    logic [31:0] m_rd2[2];
    logic [31:0] m_ext[2];
    logic [3:0]  m_rd[2];
    logic        m_bub[2];
    int          m_rem[2];      // stall cycles still owed after this one
    logic        obs_stall[2];  // stall seen on the DUT in the last cycle

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ctrl[k] = '0; m_rd1[k] = '0; m_rd2[k] = '0; m_ext[k] = '0;
            m_rd[k] = '0; m_bub[k] = 1'b0; m_rem[k] = 0;
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, " ctrl1"}, 64'(ifc1.ex_ctrl), 64'(m_ctrl[0]));
        chk({pfx, " rd1_1"}, 64'(ifc1.ex_rd1),  64'(m_rd1[0]));
        chk({pfx, " rd2_1"}, 64'(ifc1.ex_rd2),  64'(m_rd2[0]));
        chk({pfx, " ext1"},  64'(ifc1.ex_ext),  64'(m_ext[0]));
        chk({pfx, " rd_1"},  64'(ifc1.ex_rd),   64'(m_rd[0]));
        chk({pfx, " bub1"},  64'(ifc1.bubble),  64'(m_bub[0]));
        chk({pfx, " ctrl3"}, 64'(ifc3.ex_ctrl), 64'(m_ctrl[1]));
        chk({pfx, " rd1_3"}, 64'(ifc3.ex_rd1),  64'(m_rd1[1]));
        chk({pfx, " rd2_3"}, 64'(ifc3.ex_rd2),  64'(m_rd2[1]));
        chk({pfx, " ext3"},  64'(ifc3.ex_ext),  64'(m_ext[1]));
        chk({pfx, " rd_3"},  64'(ifc3.ex_rd),   64'(m_rd[1]));
        chk({pfx, " bub3"},  64'(ifc3.bubble),  64'(m_bub[1]));
    endtask

    // One clock: called at a falling edge, drives ID inputs, checks stall,
    // then checks the registered EX side after the rising edge.
    task automatic cycle(input logic [11:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e,
                         input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic u1, input logic u2,
                         input logic [3:0] rd, input logic fl);
        logic        haz, st, nop;
        logic [11:0] n_ctrl[2];
        logic [31:0] n_rd1[2], n_rd2[2], n_ext[2];
        logic [3:0]  n_rd[2];
        logic        n_bub[2];
        int          n_rem[2];
        ifc1.id_ctrl = ctrl; ifc3.id_ctrl = ctrl;
        ifc1.id_rd1 = a;     ifc3.id_rd1 = a;
        ifc1.id_rd2 = b;     ifc3.id_rd2 = b;
        ifc1.id_ext = e;     ifc3.id_ext = e;
        ifc1.id_rs1 = rs1;   ifc3.id_rs1 = rs1;
        ifc1.id_rs2 = rs2;   ifc3.id_rs2 = rs2;
        ifc1.id_use_rs1 = u1; ifc3.id_use_rs1 = u1;
        ifc1.id_use_rs2 = u2; ifc3.id_use_rs2 = u2;
        ifc1.id_rd = rd;     ifc3.id_rd = rd;
        ifc1.ex_flush = fl;  ifc3.ex_flush = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            haz = m_ctrl[k][10] && ((u1 && rs1 == m_rd[k]) || (u2 && rs2 == m_rd[k]));
            st = 1'b0;
            nop = 1'b1;
            n_rem[k] = m_rem[k];
            if (m_rem[k] > 0) begin
                if (fl) n_rem[k] = 0;
                else begin st = 1'b1; n_rem[k] = m_rem[k] - 1; end
            end else if (fl) begin
                nop = 1'b1;
            end else if (haz) begin
                st = 1'b1;
                n_rem[k] = ls_val[k] - 1;
            end else begin
                nop = 1'b0;
            end
            n_ctrl[k] = nop ? 12'h0 : ctrl;
            n_rd1[k]  = nop ? 32'h0 : a;
            n_rd2[k]  = nop ? 32'h0 : b;
            n_ext[k]  = nop ? 32'h0 : e;
            n_rd[k]   = nop ? 4'h0 : rd;
            n_bub[k]  = nop;
            obs_stall[k] = (k == 0) ? ifc1.stall : ifc3.stall;
            chk($sformatf("stall[LS=%0d]", ls_val[k]), 64'(obs_stall[k]), 64'(st));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_ctrl[k] = n_ctrl[k]; m_rd1[k] = n_rd1[k]; m_rd2[k] = n_rd2[k];
            m_ext[k] = n_ext[k]; m_rd[k] = n_rd[k]; m_bub[k] = n_bub[k];
            m_rem[k] = n_rem[k];
        end
        check_outputs("ex");
        @(negedge clk);
    endtask

    localparam logic [11:0] LOAD = 12'h600;  // rmem + wreg
    localparam logic [11:0] ADD  = 12'h0A5;

    int cnt1, cnt3;

    initial begin
        rst = 1'b1;
        cycle_inputs_zero();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("rst");
        chk("rst stall1", 64'(ifc1.stall), 64'd0);
        chk("rst stall3", 64'(ifc3.stall), 64'd0);
        rst = 1'b0;

        // Plain ALU op passes through in one cycle.
        cycle(ADD, 32'd5, 32'd7, 32'd9, 4'd1, 4'd2, 1'b1, 1'b1, 4'd6, 1'b0);
        chk("t1 ctrl", 64'(ifc1.ex_ctrl), 64'h0A5);
        chk("t1 rd1",  64'(ifc1.ex_rd1),  64'd5);

        // Load-use on rs1: one vs three bubbles, then the add issues.
        cycle(LOAD, 32'd1, 32'd2, 32'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0);
        cnt1 = 0; cnt3 = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(ADD, 32'd11, 32'd12, 32'd13, 4'd3, 4'd4, 1'b1, 1'b1, 4'd8, 1'b0);
            cnt1 += int'(obs_stall[0]);
            cnt3 += int'(obs_stall[1]);
        end
        chk("t2 stall count LS=1", 64'(cnt1), 64'd1);
        chk("t3 stall count LS=3", 64'(cnt3), 64'd3);
        chk("t3 add issued", 64'(ifc3.ex_ctrl), 64'h0A5);

        // Match on rs2 that is not read: no stall.
        cycle(LOAD, 32'd1, 32'd2, 32'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0);
        cycle(ADD, 32'd4, 32'd5, 32'd6, 4'd5, 4'd3, 1'b1, 1'b0, 4'd9, 1'b0);
        chk("t4 no stall", 64'(obs_stall[1]), 64'd0);

        // Flush together with a hazard, then flush while in STALL.
        cycle(LOAD, 32'd1, 32'd2, 32'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0);
        cycle(ADD, 32'd4, 32'd5, 32'd6, 4'd3, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1);
        cycle(LOAD, 32'd1, 32'd2, 32'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0);
        cycle(ADD, 32'd4, 32'd5, 32'd6, 4'd3, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0);
        cycle(ADD, 32'd4, 32'd5, 32'd6, 4'd3, 4'd0, 1'b1, 1'b0, 4'd9, 1'b1);
        cycle(ADD, 32'd4, 32'd5, 32'd6, 4'd3, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0);
        chk("t5 issue after flush", 64'(ifc3.ex_ctrl), 64'h0A5);

        // Asynchronous reset in the middle of a STALL sequence.
        cycle(LOAD, 32'd1, 32'd2, 32'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0);
        cycle(ADD, 32'd4, 32'd5, 32'd6, 4'd3, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("arst");
        chk("arst stall3", 64'(ifc3.stall), 64'd0);
        @(posedge clk);
        #1;
        chk("arst hold stall3", 64'(ifc3.stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(ADD, 32'd21, 32'd22, 32'd23, 4'd3, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0);
        chk("t6 first after reset", 64'(ifc3.ex_rd1), 64'd21);

        // Random traffic with small register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            cycle(12'($urandom), $urandom, $urandom, $urandom,
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    task automatic cycle_inputs_zero();
        ifc1.id_ctrl = '0; ifc3.id_ctrl = '0;
        ifc1.id_rd1 = '0;  ifc3.id_rd1 = '0;
        ifc1.id_rd2 = '0;  ifc3.id_rd2 = '0;
        ifc1.id_ext = '0;  ifc3.id_ext = '0;
        ifc1.id_rs1 = '0;  ifc3.id_rs1 = '0;
        ifc1.id_rs2 = '0;  ifc3.id_rs2 = '0;
        ifc1.id_use_rs1 = 1'b0; ifc3.id_use_rs1 = 1'b0;
        ifc1.id_use_rs2 = 1'b0; ifc3.id_use_rs2 = 1'b0;
        ifc1.id_rd = '0;   ifc3.id_rd = '0;
        ifc1.ex_flush = 1'b0; ifc3.ex_flush = 1'b0;
    endtask

endmodule
